// File: rtl/cordic_pkg.sv
// Shared constants and types for the float-to-theta front end of the CORDIC cosine path.
package cordic_pkg;
  localparam int unsigned FRACS_DEF   = 21;
  localparam int unsigned INTS_DEF    = 1;
  localparam int unsigned WIDTH_DEF   = INTS_DEF + FRACS_DEF + 1;
  localparam int unsigned FP_EXP_BIAS = 127;
  localparam int unsigned EXP_BIG     = 128;
  localparam int unsigned EXP_TINY    = 102;

  localparam logic [WIDTH_DEF-1:0] THETA_MAX = {1'b0, {(WIDTH_DEF-1){1'b1}}};
  localparam logic [WIDTH_DEF-1:0] THETA_MIN = {1'b1, {(WIDTH_DEF-2){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    NORMAL,
    ZERO,
    TINY,
    BIG,
    INF,
    NAN
  } fp_class_e;

  typedef struct packed {
    logic sat;
    logic nan;
    logic uflow;
  } conv_flags_t;

  function automatic fp_class_e fp_classify(input logic [7:0]  exp,
                                            input logic [22:0] mant,
                                            input logic [7:0]  exp_big,
                                            input logic [7:0]  exp_tiny);
    fp_class_e cls;
    if (exp == 8'hFF)        cls = (mant != '0) ? NAN : INF;
    else if (exp == '0)      cls = ZERO;
    else if (exp >= exp_big) cls = BIG;
    else if (exp <= exp_tiny) cls = TINY;
    else                     cls = NORMAL;
    return cls;
  endfunction
endpackage

// File: rtl/rne_shifter.sv
// 24-bit right barrel shifter producing the truncated magnitude plus guard and sticky bits.
module rne_shifter (
  input  logic [23:0] sig,
  input  logic [4:0]  shamt,
  output logic [23:0] mag,
  output logic        guard,
  output logic        sticky
);
  logic [49:0] ext;

  // Shifted-out bits land below bit 26 so guard/sticky fall out of the same shift.
  always_comb begin
    ext         = '0;
    ext[49:26]  = sig;
    ext         = ext >> shamt;
    mag         = ext[49:26];
    guard       = ext[25];
    sticky      = |ext[24:0];
  end
endmodule

// File: rtl/float_to_theta.sv
// 3-stage IEEE-754 single to signed Q(INTS).(FRACS) theta converter with valid/ready and clk_en stall.
module float_to_theta
  import cordic_pkg::*;
#(
  parameter int unsigned FRACS = FRACS_DEF,
  parameter int unsigned INTS  = INTS_DEF,
  parameter int unsigned WIDTH = INTS + FRACS + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      float_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] theta_out,
  output logic             flag_sat,
  output logic             flag_nan,
  output logic             flag_uflow
);
  // theta = sig * 2^(exp - SHIFT_BASE); shifts beyond 26 always round to zero.
  localparam logic [7:0]  SHIFT_BASE = 8'(FP_EXP_BIAS + 23 - FRACS);
  localparam logic [7:0]  EXP_BIG_L  = 8'(FP_EXP_BIAS + INTS);
  localparam logic [7:0]  EXP_TINY_L = 8'(FP_EXP_BIAS + 23 - FRACS - 27);
  localparam logic [24:0] MAG_MAX    = 25'((64'd1 << (WIDTH - 1)) - 64'd1);

  logic        advance;
  fp_class_e   in_class;

  logic        s1_valid, s1_sign;
  fp_class_e   s1_class;
  logic [23:0] s1_sig;
  logic [4:0]  s1_shamt;

  logic [23:0] sh_mag;
  logic        sh_guard, sh_sticky;

  logic        s2_valid, s2_sign;
  fp_class_e   s2_class;
  logic [23:0] s2_mag;
  logic        s2_guard, s2_sticky;

  logic             round_up;
  logic [24:0]      rounded;
  logic [WIDTH-2:0] mag_sel;
  logic [WIDTH-1:0] mag_ext, theta_d;
  conv_flags_t      flags_d, flags_q;

  assign advance  = clk_en & (~out_valid | out_ready);
  assign in_ready = advance;
  assign in_class = fp_classify(float_in[30:23], float_in[22:0], EXP_BIG_L, EXP_TINY_L);

  rne_shifter u_shifter (
    .sig    (s1_sig),
    .shamt  (s1_shamt),
    .mag    (sh_mag),
    .guard  (sh_guard),
    .sticky (sh_sticky)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      theta_out <= '0;
      flags_q   <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      theta_out <= theta_d;
      flags_q   <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_sign   <= float_in[31];
      s1_class  <= in_class;
      s1_sig    <= {1'b1, float_in[22:0]};
      s1_shamt  <= 5'(SHIFT_BASE - float_in[30:23]);
      s2_sign   <= s1_sign;
      s2_class  <= s1_class;
      s2_mag    <= sh_mag;
      s2_guard  <= sh_guard;
      s2_sticky <= sh_sticky;
    end
  end

  always_comb begin
    round_up = s2_guard & (s2_sticky | s2_mag[0]);
    rounded  = {1'b0, s2_mag} + {24'd0, round_up};
    mag_sel  = '0;
    flags_d  = '0;
    case (s2_class)
      NAN: flags_d.nan = 1'b1;
      INF, BIG: begin
        flags_d.sat = 1'b1;
        mag_sel     = '1;
      end
      TINY: flags_d.uflow = 1'b1;
      NORMAL: begin
        if (rounded > MAG_MAX) begin
          flags_d.sat = 1'b1;
          mag_sel     = '1;
        end else if (rounded == '0) begin
          flags_d.uflow = 1'b1;
        end else begin
          mag_sel = rounded[WIDTH-2:0];
        end
      end
      default: ;
    endcase
    // Magnitude is capped at 2^(WIDTH-1)-1, so negation is symmetric and -0 stays 0.
    mag_ext = {1'b0, mag_sel};
    theta_d = s2_sign ? ('0 - mag_ext) : mag_ext;
  end

  assign flag_sat   = flags_q.sat;
  assign flag_nan   = flags_q.nan;
  assign flag_uflow = flags_q.uflow;
endmodule

// File: tb/tb_float_to_theta.sv
// Scoreboard bench for float_to_theta: directed vectors, backpressure, clk_en freeze and reset flush.
module tb_float_to_theta;
  import cordic_pkg::*;

  logic        clk = 1'b0;
  logic        reset, clk_en, in_valid, in_ready, out_valid, out_ready;
  logic        flag_sat, flag_nan, flag_uflow;
  logic [31:0] float_in;
  logic [22:0] theta_out;

  always #5 clk = ~clk;

  float_to_theta #(.FRACS(21), .INTS(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .float_in   (float_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .theta_out  (theta_out),
    .flag_sat   (flag_sat),
    .flag_nan   (flag_nan),
    .flag_uflow (flag_uflow)
  );

  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_SAT  = 3'b100;
  localparam logic [2:0] F_NAN  = 3'b010;
  localparam logic [2:0] F_UF   = 3'b001;

  typedef struct {
    logic [31:0] f;
    logic [22:0] theta;
    logic [2:0]  flags;
    int unsigned adv;
  } exp_t;

  typedef struct {
    logic [31:0] f;
    logic [22:0] t;
    logic [2:0]  fl;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs [0:22];
  int          checks = 0;
  int          failures = 0;
  int unsigned adv_cnt = 0;
  int unsigned n_out = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Call at a falling edge; returns at the falling edge after the item was accepted.
  task automatic send(input logic [31:0] f, input logic [22:0] t, input logic [2:0] fl);
    bit done = 1'b0;
    int tries = 0;
    exp_t e;
    in_valid = 1'b1;
    float_in = f;
    while (!done) begin
      #1;
      if (in_ready && !reset) begin
        e.f = f; e.theta = t; e.flags = fl; e.adv = adv_cnt;
        sb.push_back(e);
        done = 1'b1;
      end
      @(negedge clk);
      tries++;
      if (!done && tries > 100) begin
        checks++; failures++;
        $display("FAIL send_timeout input=%h in_ready=%b required=1", f, in_ready);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  // Monitor: pops on each output transfer and checks that stalled cycles change nothing.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!reset && hold_prev)
      check("hold_stable", {5'd0, out_valid, flag_sat, flag_nan, flag_uflow, theta_out}, hold_val);
    if (!reset && clk_en && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output theta=%h required=none", theta_out);
      end else begin
        e = sb.pop_front();
        check($sformatf("theta[%h]", e.f), {9'd0, theta_out}, {9'd0, e.theta});
        check($sformatf("flags[%h]", e.f), {29'd0, flag_sat, flag_nan, flag_uflow}, {29'd0, e.flags});
        check($sformatf("latency[%h]", e.f), adv_cnt - e.adv, 3);
      end
    end
    hold_prev = !reset && !(clk_en && (!out_valid || out_ready));
    hold_val  = {5'd0, out_valid, flag_sat, flag_nan, flag_uflow, theta_out};
    if (!reset && clk_en && (!out_valid || out_ready)) adv_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n_before;
    vecs = '{
      '{32'h3F490FDB, 23'h1921FB, F_NONE},
      '{32'h3F000000, 23'h100000, F_NONE},
      '{32'h40000000, THETA_MAX,  F_SAT},
      '{32'h3FFFFFFF, THETA_MAX,  F_SAT},
      '{32'hFF800000, THETA_MIN,  F_SAT},
      '{32'h7FC00000, 23'h000000, F_NAN},
      '{32'h33800000, 23'h000000, F_UF},
      '{32'h80000000, 23'h000000, F_NONE},
      '{32'h00000001, 23'h000000, F_NONE},
      '{32'hBF800000, 23'h600000, F_NONE},
      '{32'h3FFFFFFD, 23'h3FFFFF, F_NONE},
      '{32'hBFFFFFFD, 23'h400001, F_NONE},
      '{32'h3F7FFFFF, 23'h200000, F_NONE},
      '{32'h3F800006, 23'h200002, F_NONE},
      '{32'h3F800002, 23'h200000, F_NONE},
      '{32'h34C00000, 23'h000001, F_NONE},
      '{32'h34800000, 23'h000000, F_UF},
      '{32'h35000000, 23'h000001, F_NONE},
      '{32'h33000000, 23'h000000, F_UF},
      '{32'h7F7FFFFF, THETA_MAX,  F_SAT},
      '{32'hC0000000, THETA_MIN,  F_SAT},
      '{32'hFFC00001, 23'h000000, F_NAN},
      '{32'h807FFFFF, 23'h000000, F_NONE}
    };
    reset = 1'b1; clk_en = 1'b1; in_valid = 1'b0; float_in = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #3;
    check("reset_out_valid", out_valid, 0);
    check("reset_theta", theta_out, 0);
    check("reset_flags", {flag_sat, flag_nan, flag_uflow}, 0);
    @(negedge clk);

    send(32'h3F800000, 23'h200000, F_NONE);
    send(32'hBF000000, 23'h700000, F_NONE);
    drain();

    for (int i = 0; i < 23; i++) send(vecs[i].f, vecs[i].t, vecs[i].fl);
    drain();

    fork
      begin
        for (int i = 0; i < 6; i++) send(vecs[i].f, vecs[i].t, vecs[i].fl);
      end
      begin
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("in_ready_pipe_full", in_ready, 0);
        @(negedge clk);
        for (int k = 0; k < 14; k++) begin
          out_ready = (k % 2 == 0);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    fork
      begin
        for (int i = 6; i < 11; i++) send(vecs[i].f, vecs[i].t, vecs[i].fl);
      end
      begin
        repeat (2) @(negedge clk);
        clk_en = 1'b0;
        repeat (5) @(negedge clk);
        clk_en = 1'b1;
      end
    join
    drain();

    send(vecs[11].f, vecs[11].t, vecs[11].fl);
    send(vecs[12].f, vecs[12].t, vecs[12].fl);
    reset = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #3;
    check("flush_out_valid", out_valid, 0);
    check("flush_theta", theta_out, 0);
    check("flush_flags", {flag_sat, flag_nan, flag_uflow}, 0);
    n_before = n_out;
    repeat (8) @(negedge clk);
    check("flush_no_emerge", n_out, n_before);

    send(32'h3F000000, 23'h100000, F_NONE);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/float_to_theta.md
Name: float_to_theta

Overview:
Converts IEEE-754 single-precision angles from the host interface into the signed fixed-point theta (1 sign, INTS integer, FRACS fraction bits) consumed by the downstream CORDIC cosine stage. It is a 3-stage pipeline with a valid/ready handshake and a global clk_en stall. Out-of-range, special and tiny inputs are saturated or flushed deterministically and flagged.

Parameters:
FRACS, 21, fraction bits of theta
INTS, 1, integer bits of theta (excluding sign)
WIDTH, INTS+FRACS+1, theta width including sign bit (23)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
clk_en  in  1  global pipeline enable; 0 freezes all state
in_valid  in  1  float_in is valid
in_ready  out  1  block accepts float_in this cycle
float_in  in  32  IEEE-754 single: sign[31], exp[30:23], mant[22:0]
out_valid  out  1  theta_out and flags are valid
out_ready  in  1  downstream accepts the result
theta_out  out  WIDTH  signed two's-complement Q(INTS).(FRACS) angle
flag_sat  out  1  result was saturated (|x| too large, rounding overflow, or ±Inf)
flag_nan  out  1  input was NaN; theta_out = 0
flag_uflow  out  1  nonzero finite input rounded to 0

Behaviour:
- Reset (synchronous, active-high, dominates clk_en): all stage-valid bits cleared; out_valid=0, theta_out=0, all flags=0. Reset mid-operation discards in-flight data; no output for those inputs.
- advance = clk_en & (~out_valid | out_ready); in_ready = advance (combinational). Transfer in when in_valid & in_ready; out when out_valid & out_ready.
- Latency exactly 3 advancing cycles from input transfer to out_valid; throughput 1/cycle with out_ready=1. When advance=0 every stage register (data and valid) holds; theta_out/flags stable while out_valid & ~out_ready.
- S1 unpack/classify: sig = {1,mant} (24 b); class = NaN (exp=255, mant≠0), Inf (exp=255, mant=0), zero/denormal (exp=0, flushed to zero, no flag), big (exp≥128), tiny (exp≤102), normal.
- S2 shift: normal path: magnitude = sig × 2^(exp−129) × 2^0, i.e. right shift by 129−exp (2..26); keep guard bit and OR of all lower bits as sticky.
- S3 round/sign/saturate: round-to-nearest-even on guard/sticky; if rounded magnitude > 2^(WIDTH−1)−1, saturate. Saturated value is symmetric: +0x3FFFFF / −0x3FFFFF (0x400001); never 0x400000. Negate if sign=1; −0 gives 0.
- Special results: NaN → 0, flag_nan=1; Inf or big → ±max, flag_sat=1; tiny, or normal rounding to 0 → 0, flag_uflow=1; zero/denormal → 0, no flags.
- Flags travel with their datum; exactly one of {sat, nan, uflow} or none per result.

Decomposition:
- Package cordic_pkg: FRACS/INTS/WIDTH defaults, FP_EXP_BIAS=127, EXP_BIG=128, EXP_TINY=102, THETA_MAX/THETA_MIN constants, fp_class_e enum (NORMAL, ZERO, TINY, BIG, INF, NAN), conv_flags_t struct {sat, nan, uflow}.
- One sub-module: rne_shifter. It is a combinational 24-bit right barrel shifter with guard/sticky output, instantiated in S2. Rounding is done in S3.

Test Plan:
- 0x3F800000 (1.0) then 0xBF000000 (−0.5) back-to-back, out_ready=1 -> after 3 cycles: 0x200000, then next cycle 0x700000; no flags.
- 0x3F490FDB (π/4) -> 0x1921FB (1647099.375 rounds down); 0x3F000000 (0.5) -> 0x100000.
- 0x40000000 (2.0) -> 0x3FFFFF with flag_sat; 0x3FFFFFFF (rounds up to 2^22) -> 0x3FFFFF with flag_sat; 0xFF800000 (−Inf) -> 0x400001 with flag_sat.
- Specials: 0x7FC00000 -> 0 with flag_nan; 0x33800000 (2^−24) -> 0 with flag_uflow; 0x80000000 (−0) -> 0, no flags; 0x00000001 (denormal) -> 0, no flags.
- Backpressure: stream 6 inputs with out_ready held low 4 cycles, then toggled 1/0 -> in_ready drops once the pipe is full; all 6 results appear in order, none lost or duplicated, output stable while stalled.
- clk_en=0 for 5 cycles mid-stream, and reset asserted with 2 items in flight -> freeze with no output change; after reset out_valid=0, theta_out=0, flags=0, and in-flight items never emerge.
